write_back: RTL and testbench

Final pipeline stage of the five-stage RV64 core, directly downstream of the memory-access stage. Registers memory-stage results (the MEM/WB boundary) and selects ALU result or load data as the register-file write value. Drives the register-file write port and the WB-stage forwarding path. Maintains a 64-bit retired-instruction counter.

---
 rtl/write_back_pkg.sv | 6 +
 rtl/pipe_reg.sv | 16 +
 rtl/write_back.sv | 51 +++++
 tb/tb_write_back.sv | 114 +++++++++++
 4 files changed

// File: rtl/write_back_pkg.sv
// write_back_pkg: shared write-back select and register-index constants
package write_back_pkg;
  localparam logic WB_SEL_ALU = 1'b0;
  localparam logic WB_SEL_MEM = 1'b1;
  localparam logic [4:0] REG_ZERO = 5'd0;
endpackage

// File: rtl/pipe_reg.sv
// pipe_reg: pipeline boundary register with reset > flush > stall priority
module pipe_reg #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         stall,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  // flush zeroes every field so a squashed entry carries no stale payload
  always_ff @(posedge clk)
    if (rst || flush) q <= '0;
    else if (!stall) q <= d;
endmodule

// File: rtl/write_back.sv
// write_back: MEM/WB register, write-back mux, x0-filtered write strobe and retire counter
module write_back
  import write_back_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int CNT_W = 64
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             m_valid_i,
  input  logic [XLEN-1:0]  m_pc_i,
  input  logic [XLEN-1:0]  m_alu_result_i,
  input  logic [XLEN-1:0]  m_mem_rdata_i,
  input  logic             m_reg_wen_i,
  input  logic             m_reg_mux_i,
  input  logic [4:0]       m_reg_waddr_i,
  input  logic             w_stall_i,
  input  logic             w_flush_i,
  output logic             w_valid_o,
  output logic [XLEN-1:0]  w_pc_o,
  output logic             w_reg_wen_o,
  output logic [4:0]       w_reg_waddr_o,
  output logic [XLEN-1:0]  w_reg_wdata_o,
  output logic             w_fwd_valid_o,
  output logic [CNT_W-1:0] w_instret_o
);
  localparam int W = 3 * XLEN + 8;
  logic            r_valid, r_reg_wen, r_reg_mux;
  logic [XLEN-1:0] r_pc, r_alu, r_rdata;
  logic [4:0]      r_waddr;
  logic [W-1:0]    q;
  pipe_reg #(.W(W)) u_mem_wb (
    .clk  (clk_i),
    .rst  (rst_i),
    .flush(w_flush_i),
    .stall(w_stall_i),
    .d    ({m_valid_i, m_pc_i, m_alu_result_i, m_mem_rdata_i, m_reg_wen_i, m_reg_mux_i, m_reg_waddr_i}),
    .q    (q)
  );
  assign {r_valid, r_pc, r_alu, r_rdata, r_reg_wen, r_reg_mux, r_waddr} = q;
  assign w_valid_o     = r_valid;
  assign w_pc_o        = r_pc;
  assign w_reg_waddr_o = r_waddr;
  assign w_reg_wdata_o = (r_reg_mux == WB_SEL_MEM) ? r_rdata : r_alu;
  assign w_reg_wen_o   = r_valid && r_reg_wen && (r_waddr != REG_ZERO);
  assign w_fwd_valid_o = w_reg_wen_o;
  // an instruction retires on the edge it leaves the stage; a flushed one never does
  always_ff @(posedge clk_i)
    if (rst_i) w_instret_o <= '0;
    else if (r_valid && !w_stall_i && !w_flush_i) w_instret_o <= w_instret_o + CNT_W'(1);
endmodule

// File: tb/tb_write_back.sv
// tb_write_back: directed and random checks of write_back against a retire-queue model
module tb_write_back;
  logic        clk = 1'b0;
  logic        rst, m_valid, m_wen, m_mux, stall, flush;
  logic [63:0] m_pc, m_alu, m_rdata;
  logic [4:0]  m_waddr;
  logic        w_valid, w_wen, w_fwd;
  logic [63:0] w_pc, w_wdata, w_instret;
  logic [4:0]  w_waddr;
  logic        s_valid, s_wen, s_fwd;
  logic [63:0] s_pc, s_wdata;
  logic [4:0]  s_waddr;
  logic [2:0]  s_instret;
  int n_vec = 0, n_bad = 0;
  logic        e_valid, e_wen, e_mux;
  logic [63:0] e_pc, e_alu, e_rdata;
  logic [4:0]  e_waddr;
  logic [63:0] retired[$];

  always #5 clk = ~clk;

  write_back dut (
    .clk_i(clk), .rst_i(rst), .m_valid_i(m_valid), .m_pc_i(m_pc), .m_alu_result_i(m_alu),
    .m_mem_rdata_i(m_rdata), .m_reg_wen_i(m_wen), .m_reg_mux_i(m_mux), .m_reg_waddr_i(m_waddr),
    .w_stall_i(stall), .w_flush_i(flush), .w_valid_o(w_valid), .w_pc_o(w_pc),
    .w_reg_wen_o(w_wen), .w_reg_waddr_o(w_waddr), .w_reg_wdata_o(w_wdata),
    .w_fwd_valid_o(w_fwd), .w_instret_o(w_instret)
  );

  // narrow counter instance so wrap-around is reached in a few cycles
  write_back #(.CNT_W(3)) dut_small (
    .clk_i(clk), .rst_i(rst), .m_valid_i(m_valid), .m_pc_i(m_pc), .m_alu_result_i(m_alu),
    .m_mem_rdata_i(m_rdata), .m_reg_wen_i(m_wen), .m_reg_mux_i(m_mux), .m_reg_waddr_i(m_waddr),
    .w_stall_i(stall), .w_flush_i(flush), .w_valid_o(s_valid), .w_pc_o(s_pc),
    .w_reg_wen_o(s_wen), .w_reg_waddr_o(s_waddr), .w_reg_wdata_o(s_wdata),
    .w_fwd_valid_o(s_fwd), .w_instret_o(s_instret)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    logic ewen;
    ewen = e_valid && e_wen && (e_waddr != 5'd0);
    chk("valid", 64'(w_valid), 64'(e_valid));
    chk("pc", w_pc, e_valid || e_pc != 0 ? e_pc : 64'd0);
    chk("waddr", 64'(w_waddr), 64'(e_waddr));
    chk("wdata", w_wdata, e_mux ? e_rdata : e_alu);
    chk("wen", 64'(w_wen), 64'(ewen));
    chk("fwd", 64'(w_fwd), 64'(ewen));
    chk("instret", w_instret, 64'(retired.size()));
    chk("instret_wrap", 64'(s_instret), 64'(retired.size() % 8));
  endtask

  task automatic step(input logic r, input logic st, input logic fl, input logic v,
                      input logic [63:0] pc, input logic [63:0] alu, input logic [63:0] rd,
                      input logic wen, input logic mux, input logic [4:0] wa);
    rst = r; stall = st; flush = fl; m_valid = v; m_pc = pc; m_alu = alu;
    m_rdata = rd; m_wen = wen; m_mux = mux; m_waddr = wa;
    @(posedge clk);
    if (r) begin
      retired.delete();
      {e_valid, e_pc, e_alu, e_rdata, e_wen, e_mux, e_waddr} = '0;
    end else begin
      if (e_valid && !st && !fl) retired.push_back(e_pc);
      if (fl) {e_valid, e_pc, e_alu, e_rdata, e_wen, e_mux, e_waddr} = '0;
      else if (!st) {e_valid, e_pc, e_alu, e_rdata, e_wen, e_mux, e_waddr} = {v, pc, alu, rd, wen, mux, wa};
    end
    #1 check_all();
  endtask

  initial begin
    {e_valid, e_pc, e_alu, e_rdata, e_wen, e_mux, e_waddr} = '0;
    step(1, 0, 0, 1, 64'h40, 64'h55, 64'h66, 1, 0, 5'd3);
    step(1, 1, 1, 1, 64'h44, 64'h77, 64'h88, 1, 1, 5'd4);
    chk("rst_instret", w_instret, 64'd0);
    chk("rst_wen", 64'(w_wen), 64'd0);
    step(0, 0, 0, 1, 64'h100, 64'h1234, 64'hFFFF, 1, 0, 5'd5);
    chk("alu_wdata", w_wdata, 64'h1234);
    chk("alu_wen", 64'(w_wen), 64'd1);
    step(0, 0, 0, 1, 64'h104, 64'h9, 64'hFFFF_FFFF_FFFF_FF80, 1, 1, 5'd7);
    chk("alu_retired", w_instret, 64'd1);
    chk("load_wdata", w_wdata, 64'hFFFF_FFFF_FFFF_FF80);
    step(0, 0, 0, 1, 64'h108, 64'h9, 64'hFFFF_FFFF_FFFF_FF80, 1, 1, 5'd0);
    chk("x0_wen", 64'(w_wen), 64'd0);
    step(0, 0, 0, 1, 64'h10C, 64'hAB, 64'hCD, 1, 0, 5'd9);
    chk("x0_retired", w_instret, 64'd3);
    for (int i = 0; i < 3; i++)
      step(0, 1, 0, 1, 64'h200 + 64'(i), 64'h300 + 64'(i), 64'h1, 1, 1, 5'd10 + 5'(i));
    chk("stall_pc", w_pc, 64'h10C);
    chk("stall_instret", w_instret, 64'd3);
    step(0, 0, 0, 0, 64'h300, 64'h0, 64'h0, 1, 0, 5'd1);
    chk("release_instret", w_instret, 64'd4);
    chk("bubble_wen", 64'(w_wen), 64'd0);
    step(0, 0, 0, 1, 64'h400, 64'h5, 64'h6, 1, 0, 5'd2);
    step(0, 1, 1, 1, 64'h404, 64'h7, 64'h8, 1, 0, 5'd3);
    chk("flush_valid", 64'(w_valid), 64'd0);
    chk("flush_instret", w_instret, 64'd4);
    for (int i = 0; i < 10; i++)
      step(0, 0, 0, 1, 64'h500 + 64'(4 * i), 64'(i), 64'(i), 0, 0, 5'd0);
    chk("wrap_small", 64'(s_instret), 64'(13 % 8));
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 49) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0,
           $urandom_range(0, 4) != 0, {$urandom, $urandom}, {$urandom, $urandom},
           {$urandom, $urandom}, 1'($urandom), 1'($urandom), 5'($urandom_range(0, 3) == 0 ? 0 : $urandom));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
